// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-fetch bus bundle: the request/response link to instruction memory
// and the instruction hand-off to decode. The master side is the fetch controller.
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef PC_START
`define PC_START 32'h0000_0000
`endif

interface inst_fetch_ctrl_if;
  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [`INST_ADDR_BUS] imem_req_addr_o;
  logic                  imem_resp_valid_i;
  logic [31:0]           imem_resp_data_i;
  logic                  inst_valid_o;
  logic                  inst_ready_i;
  logic [31:0]           inst_o;
  logic [`INST_ADDR_BUS] inst_pc_o;

  modport master (
    output imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o,
    input  imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i, inst_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_req_addr_o, inst_valid_o, inst_o, inst_pc_o,
    output imem_req_ready_i, imem_resp_valid_i, imem_resp_data_i, inst_ready_i
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, in-order fetch queue, redirect flush.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a HALT trap on misaligned redirect targets.
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef PC_START
`define PC_START 32'h0000_0000
`endif

module inst_fetch_ctrl #(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  transfer_en_i,
  input  logic [`INST_ADDR_BUS] transfer_pc_i,
  inst_fetch_ctrl_if.master     bus
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misalign_o
`endif
);
  typedef logic [`INST_ADDR_BUS] addr_t;
  localparam int AW = $bits(addr_t);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam addr_t PC_RST = `PC_START;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
`ifdef FETCH_MISALIGN_TRAP_EN
    , HALT
`endif
  } state_e;

  state_e                 state_q, state_d;
  addr_t                  pc_q, pc_d;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]          occ_q, occ_d, infl_q, infl_d;
  logic [QUEUE_DEPTH-1:0] full_q, full_d;
  addr_t                  slot_pc_q   [QUEUE_DEPTH];
  logic [31:0]            slot_data_q [QUEUE_DEPTH];

  logic  req_valid, req_fire, inst_valid, pop, resp_keep, redirect;
  addr_t redirect_pc;

  assign redirect_pc = {transfer_pc_i[AW-1:2], 2'b00};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  assign redirect         = transfer_en_i && (state_q != HALT);
  assign fetch_misalign_o = misalign_q;
`else
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^transfer_pc_i[1:0];
  assign redirect      = transfer_en_i;
`endif

  // A redirect suppresses both handshakes in its own cycle; a pop frees its slot for a same-cycle request.
  assign inst_valid = (state_q == FETCH) && full_q[head_q] && !transfer_en_i;
  assign pop        = inst_valid && bus.inst_ready_i;
  assign req_valid  = (state_q == FETCH) && !transfer_en_i && ((occ_q < DEPTH_C) || pop);
  assign req_fire   = req_valid && bus.imem_req_ready_i;
  assign resp_keep  = bus.imem_resp_valid_i && (state_q == FETCH) && !transfer_en_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    fill_d  = fill_q;
    occ_d   = occ_q;
    infl_d  = infl_q;
    full_d  = full_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    if (bus.imem_resp_valid_i && (infl_q != '0)) infl_d = infl_q - CW'(1);
    if (req_fire) begin
      pc_d   = pc_q + AW'(4);
      tail_d = tail_q + PW'(1);
      occ_d  = occ_d + CW'(1);
      infl_d = infl_d + CW'(1);
    end
    if (pop) begin
      full_d[head_q] = 1'b0;
      head_d         = head_q + PW'(1);
      occ_d          = occ_d - CW'(1);
    end
    if (resp_keep) begin
      full_d[fill_q] = 1'b1;
      fill_d         = fill_q + PW'(1);
    end
    case (state_q)
      IDLE:    state_d = FETCH;
      FLUSH:   if (infl_d == '0) state_d = FETCH;
      default: ;
    endcase
    // Stale in-flight responses are still counted in infl so FLUSH can drop them.
    if (redirect) begin
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      occ_d  = '0;
      full_d = '0;
      pc_d   = redirect_pc;
      if ((state_q == FLUSH) || (infl_d != '0)) state_d = FLUSH;
      else                                      state_d = FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (transfer_pc_i[1:0] != 2'b00) begin
        state_d    = HALT;
        misalign_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= PC_RST;
      head_q  <= '0;
      tail_q  <= '0;
      fill_q  <= '0;
      occ_q   <= '0;
      infl_q  <= '0;
      full_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      fill_q  <= fill_d;
      occ_q   <= occ_d;
      infl_q  <= infl_d;
      full_q  <= full_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  // Slot payloads need no reset: the full flags qualify every read.
  always_ff @(posedge clk) begin
    if (req_fire)  slot_pc_q[tail_q]   <= pc_q;
    if (resp_keep) slot_data_q[fill_q] <= bus.imem_resp_data_i;
  end

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_req_addr_o  = pc_q;
  assign bus.inst_valid_o     = inst_valid;
  assign bus.inst_o           = inst_valid ? slot_data_q[head_q] : 32'h0;
  assign bus.inst_pc_o        = inst_valid ? slot_pc_q[head_q] : pc_q;
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus randomized traffic against a
// queue-based reference model and a latency-configurable instruction memory.
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef PC_START
`define PC_START 32'h0000_0000
`endif

module tb_inst_fetch_ctrl;
  localparam int D = 2;
  typedef logic [`INST_ADDR_BUS] addr_t;
  localparam addr_t PC0 = `PC_START;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  tr = 1'b0;
  addr_t tr_pc = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic  misalign;
`endif

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl #(.QUEUE_DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .transfer_en_i (tr),
    .transfer_pc_i (tr_pc),
    .bus           (bus.master)
`ifdef FETCH_MISALIGN_TRAP_EN
    , .fetch_misalign_o (misalign)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: ordered list of reserved fetches, stale-response count, mode.
  typedef struct { addr_t pc; logic filled; } ent_t;
  typedef enum {M_IDLE, M_RUN, M_FLUSH, M_HALT} mode_t;
  ent_t  mq[$];
  mode_t m_mode;
  addr_t m_pc;
  int    m_stale;
  logic  m_mis;

  typedef struct { logic [31:0] data; int due; } mr_t;
  mr_t mem_q[$];
  int  mem_lat  = 1;
  int  last_due = 0;

  logic  s_rv, s_iv, s_fire;
  addr_t s_addr, s_ipc;

  function automatic logic [31:0] memdata(addr_t a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int unfilled();
    int n = 0;
    foreach (mq[i]) if (!mq[i].filled) n++;
    return n;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode   = M_IDLE;
    m_pc     = PC0;
    m_stale  = 0;
    m_mis    = 1'b0;
    mem_q.delete();
    last_due = cyc;
  endtask

  task automatic tick();
    logic        exp_rv, exp_iv, rvld, done;
    logic [31:0] rdata;
    int          unf, due;
    mode_t       prev;
    rvld  = 1'b0;
    rdata = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rvld  = 1'b1;
      rdata = mem_q[0].data;
      void'(mem_q.pop_front());
    end
    bus.imem_resp_valid_i = rvld;
    bus.imem_resp_data_i  = rdata;
    @(negedge clk);
    exp_iv = (m_mode == M_RUN) && !tr && mq.size() > 0 && mq[0].filled;
    exp_rv = (m_mode == M_RUN) && !tr && (mq.size() < D || (exp_iv && bus.inst_ready_i));
    check("req_valid", 32'(bus.imem_req_valid_o), 32'(exp_rv));
    if (exp_rv) check("req_addr", 32'(bus.imem_req_addr_o), 32'(m_pc));
    check("inst_valid", 32'(bus.inst_valid_o), 32'(exp_iv));
    if (exp_iv) begin
      check("inst", bus.inst_o, memdata(mq[0].pc));
      check("inst_pc", 32'(bus.inst_pc_o), 32'(mq[0].pc));
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misalign", 32'(misalign), 32'(m_mis));
`endif
    s_rv   = bus.imem_req_valid_o;
    s_iv   = bus.inst_valid_o;
    s_addr = bus.imem_req_addr_o;
    s_ipc  = bus.inst_pc_o;
    s_fire = bus.imem_req_valid_o && bus.imem_req_ready_i;
    if (s_fire) begin
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{memdata(bus.imem_req_addr_o), due});
      last_due = due;
    end
    prev = m_mode;
    unf  = unfilled();
    if (rvld) begin
      if (prev == M_RUN && !tr) begin
        done = 1'b0;
        foreach (mq[i]) if (!done && !mq[i].filled) begin mq[i].filled = 1'b1; done = 1'b1; end
      end else if (prev == M_RUN) begin
        if (unf > 0) unf--;
      end else if (m_stale > 0) begin
        m_stale--;
      end
    end
    if (exp_iv && bus.inst_ready_i) void'(mq.pop_front());
    if (exp_rv && bus.imem_req_ready_i) begin
      mq.push_back('{m_pc, 1'b0});
      m_pc = m_pc + addr_t'(4);
    end
    if (prev == M_IDLE) m_mode = M_RUN;
    else if (prev == M_FLUSH && m_stale == 0) m_mode = M_RUN;
    if (tr && prev != M_HALT) begin
      if (prev != M_FLUSH) m_stale = unf;
      mq.delete();
      m_pc   = tr_pc & ~addr_t'(3);
      m_mode = (prev == M_FLUSH || m_stale > 0) ? M_FLUSH : M_RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (tr_pc[1:0] != 2'b00) begin
        m_mode = M_HALT;
        m_mis  = 1'b1;
      end
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tr  = 1'b0;
    bus.imem_resp_valid_i = 1'b0;
    bus.imem_resp_data_i  = '0;
    @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid_o), 32'd0);
    check("rst_req_addr", 32'(bus.imem_req_addr_o), 32'(PC0));
    check("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
    check("rst_inst", bus.inst_o, 32'd0);
    check("rst_inst_pc", 32'(bus.inst_pc_o), 32'(PC0));
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misalign", 32'(misalign), 32'd0);
`endif
    @(posedge clk);
    #1;
    cyc++;
    model_reset();
    rst = 1'b0;
  endtask

  initial begin
    int nf, n;
    bus.imem_req_ready_i  = 1'b1;
    bus.inst_ready_i      = 1'b1;
    bus.imem_resp_valid_i = 1'b0;
    bus.imem_resp_data_i  = '0;
    do_reset();

    // Streaming with 1-cycle memory: back-to-back addresses, PCs delivered in order.
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k >= 1) begin
        check("seq_valid", 32'(s_rv), 32'd1);
        check("seq_addr", 32'(s_addr), 32'(PC0 + addr_t'(4 * (k - 1))));
      end
      if (k >= 3) begin
        check("seq_inst_valid", 32'(s_iv), 32'd1);
        check("seq_inst_pc", 32'(s_ipc), 32'(PC0 + addr_t'(4 * (k - 3))));
      end
    end

    // Decode stall: exactly QUEUE_DEPTH requests, then none until a pop.
    bus.imem_req_ready_i = 1'b0;
    repeat (4) tick();
    bus.imem_req_ready_i = 1'b1;
    bus.inst_ready_i     = 1'b0;
    nf = 0;
    repeat (8) begin
      tick();
      if (s_fire) nf++;
    end
    check("stall_fires", 32'(nf), 32'(D));
    check("stall_no_req", 32'(s_rv), 32'd0);
    bus.inst_ready_i = 1'b1;
    tick();
    check("stall_pop_req", 32'(s_rv), 32'd1);

    // Redirect with two fetches in flight (3-cycle memory).
    bus.imem_req_ready_i = 1'b0;
    repeat (4) tick();
    mem_lat = 3;
    bus.imem_req_ready_i = 1'b1;
    tick();
    check("pre_flush_fire0", 32'(s_fire), 32'd1);
    tick();
    check("pre_flush_fire1", 32'(s_fire), 32'd1);
    tr    = 1'b1;
    tr_pc = addr_t'(32'h100);
    tick();
    tr = 1'b0;
    tick();
    check("flush1_no_req", 32'(s_rv), 32'd0);
    tick();
    check("flush2_no_req", 32'(s_rv), 32'd0);
    tick();
    check("redir_req", 32'(s_rv), 32'd1);
    check("redir_addr", 32'(s_addr), 32'h100);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_iv && n < 20);
    check("redir_first_iv", 32'(s_iv), 32'd1);
    check("redir_first_pc", 32'(s_ipc), 32'h100);

    // Redirect coincident with a response while decode is ready.
    mem_lat = 1;
    repeat (6) tick();
    n = 0;
    while (!(mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 10) begin
      tick();
      n++;
    end
    tr    = 1'b1;
    tr_pc = addr_t'(32'h200);
    tick();
    tr = 1'b0;
    check("coinc_no_pop", 32'(s_iv), 32'd0);
    tick();
    check("coinc_iv_next", 32'(s_iv), 32'd0);
    repeat (4) tick();

    // Fetch PC wraps modulo the address width.
    tr    = 1'b1;
    tr_pc = addr_t'(32'hFFFF_FFF8);
    tick();
    tr = 1'b0;
    repeat (8) tick();

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) mem_lat = $urandom_range(1, 3);
      bus.imem_req_ready_i = ($urandom_range(0, 3) != 0);
      bus.inst_ready_i     = ($urandom_range(0, 3) != 0);
      tr    = ($urandom_range(0, 24) == 0);
      tr_pc = addr_t'($urandom);
`ifdef FETCH_MISALIGN_TRAP_EN
      tr_pc[1:0] = 2'b00;
`endif
      tick();
    end
    tr = 1'b0;
    bus.imem_req_ready_i = 1'b1;
    bus.inst_ready_i     = 1'b1;

    // Reset mid-operation abandons in-flight fetches.
    do_reset();
    repeat (8) tick();

`ifdef FETCH_MISALIGN_TRAP_EN
    tr    = 1'b1;
    tr_pc = addr_t'(32'h102);
    tick();
    tr = 1'b0;
    repeat (8) begin
      tick();
      check("halt_no_req", 32'(s_rv), 32'd0);
    end
    check("halt_misalign", 32'(misalign), 32'd1);
    do_reset();
    tick();
    tick();
    check("resume_req", 32'(s_rv), 32'd1);
    check("resume_addr", 32'(s_addr), 32'(PC0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
